fpcvt_pipe: RTL and testbench
=============================

// Module: fpcvt_pipe
// PURPOSE
//  Streaming, parametrised successor to the combinational 12-bit FP converter.
//  Converts signed DW-bit two's-complement samples to sign/EW-bit exp/MW-bit mantissa (value = F << E).
//  3-stage pipeline with valid/ready on both sides, per-sample saturation flag and saturating overflow counter.
//  Sits between the sample source (switch/ADC front end) and display/compression logic.
// PARAMETERS
//  DW  12  input width, two's complement; constraint DW <= MW + 2**EW
//  EW  3   exponent width
//  MW  4   mantissa width
//  CW  8   width of saturation event counter
// PORTS
//  clk        in   1   single clock, all state rising-edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   in_data valid
//  in_ready   out  1   converter can accept in_data this cycle
//  in_data    in   DW  two's-complement sample
//  out_valid  out  1   out_s/out_e/out_f/out_sat valid
//  out_ready  in   1   downstream accepts result
//  out_s      out  1   sign = in_data[DW-1]
//  out_e      out  EW  exponent
//  out_f      out  MW  mantissa
//  out_sat    out  1   result clamped to max magnitude
//  sat_count  out  CW  number of accepted saturated results, sticks at all-ones
// BEHAVIOUR
//  Reset: all stage valids, out_valid, out_s/e/f, out_sat, sat_count = 0. Reset mid-stream drops in-flight samples.
//  Handshake: advance = !out_valid | out_ready; in_ready = advance. All stages move together on advance, else hold.
//   Transfer only when valid & ready. Latency 3 cycles with no stall; throughput 1/cycle; order preserved, no loss/dup.
//  S1: mag = sign ? -in_data : in_data as DW-bit unsigned. Most negative input -> mag = 2**(DW-1), saturates later.
//  S2: p = index of leading one of mag (0 if mag==0). E = (p < MW) ? 0 : p-MW+1.
//   F = mag >> E (low MW bits); guard = mag[E-1] if E>0 else 0; sticky = OR of mag[E-2:0] (0 if E<2).
//  S3 rounding: round-up when guard=1 (see CONFIGURATION). E=0 never rounds.
//   F=all-ones + 1 -> F = 1 followed by MW-1 zeros, E+1. If E+1 overflows 2**EW-1 -> clamp.
//   Exponent > 2**EW-1 before rounding -> clamp. Clamp: E=all-ones, F=all-ones, out_sat=1.
//  sat_count increments on (out_valid & out_ready & out_sat) only; holds at all-ones.
//  Zero input -> S=0,E=0,F=0,sat=0.
// CONFIGURATION
//  FPCVT_RNE_EN defined: round-to-nearest-even: up if guard & (sticky | F[0]); exact ties keep even F.
//  FPCVT_RNE_EN undefined: round-half-up: up if guard (legacy converter behaviour, sticky ignored).
// STRUCTURE
//  fpcvt_pkg: localparams NSTAGE=3, EMAX=(1<<EW)-1; function for leading-one index; stage payload struct {s,e,f,guard,sticky,sat}.
//  Sub-module fpcvt_lzd: parametrised leading-one detector (DW in, $clog2(DW) index + zero flag out), used in S2.
// TESTING (DW=12,EW=3,MW=4,CW=8)
//  in_data=12'h000 -> S=0,E=0,F=0000,sat=0 three cycles after accept.
//  in_data=12'd422 -> S=0,E=5,F=1101 (guard 0, no round).
//  in_data=12'd125 -> E=3,F=1111 rounds: E=4,F=1000,sat=0.
//  in_data=12'h7FF -> E=7,F=1111,sat=1; in_data=12'h800 -> S=1,E=7,F=1111,sat=1; sat_count=2.
//  in_data=12'd21 -> with FPCVT_RNE_EN: E=1,F=1010; without: E=1,F=1011.
//  Stream 8 samples, out_ready=0 for 5 cycles mid-stream -> in_ready=0 when full, outputs held stable, all 8 out in order.
//  rst=1 with 3 in flight -> next cycle out_valid=0, sat_count=0; no stale results afterward.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared constants and helpers for the fpcvt_pipe streaming converter.
package fpcvt_pkg;

    localparam int NSTAGE = 3;

    function automatic int emax(input int ew);
        return (1 << ew) - 1;
    endfunction

    // Returns the highest set bit position, 0 when v is zero.
    function automatic int lead_one(input logic [63:0] v);
        int p = 0;
        for (int i = 0; i < 64; i++)
            if (v[i]) p = i;
        return p;
    endfunction

endpackage

// File: rtl/fpcvt_lzd.sv
// fpcvt_lzd: parametrised leading-one detector returning the top set-bit index and a zero flag.
module fpcvt_lzd
    import fpcvt_pkg::*;
#(
    parameter int DW = 12,
    localparam int PW = $clog2(DW)
) (
    input  logic [DW-1:0] din,
    output logic [PW-1:0] idx,
    output logic          zero
);

    always_comb begin
        idx  = PW'(lead_one(64'(din)));
        zero = din == '0;
    end

endmodule

// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: 3-stage valid/ready two's-complement to sign/exp/mantissa converter with saturation count.
// Define FPCVT_RNE_EN for round-to-nearest-even; otherwise round-half-up.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int DW = 12,
    parameter int EW = 3,
    parameter int MW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_s,
    output logic [EW-1:0] out_e,
    output logic [MW-1:0] out_f,
    output logic          out_sat,
    output logic [CW-1:0] sat_count
);

    localparam int PW   = $clog2(DW);
    localparam int XW   = (PW > EW ? PW : EW) + 1;
    localparam int EMAX = emax(EW);
`ifdef FPCVT_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct packed {
        logic          s;
        logic [EW-1:0] e;
        logic [MW-1:0] f;
        logic          guard;
        logic          sticky;
        logic          sat;
    } pay_t;

    logic          advance;
    logic          s1_v_q, s1_v_d, s1_s_q, s1_s_d;
    logic [DW-1:0] s1_mag_q, s1_mag_d;
    logic          s2_v_q, s2_v_d;
    pay_t          s2_q, s2_d;
    logic          out_valid_q, out_valid_d, out_s_q, out_s_d, out_sat_q, out_sat_d;
    logic [EW-1:0] out_e_q, out_e_d;
    logic [MW-1:0] out_f_q, out_f_d;
    logic [CW-1:0] sat_count_q, sat_count_d;
    logic [PW-1:0] lead;
    logic          zero, sat2, round_up, ovf;
    logic [XW-1:0] e_x;
    logic [DW-1:0] low_mask;
    logic [MW:0]   f_rnd;

    fpcvt_lzd #(.DW(DW)) u_lzd (.din(s1_mag_q), .idx(lead), .zero(zero));

    always_comb begin
        advance  = !out_valid_q || out_ready;
        s1_v_d   = advance ? in_valid : s1_v_q;
        s1_s_d   = advance ? in_data[DW-1] : s1_s_q;
        s1_mag_d = advance ? (in_data[DW-1] ? -in_data : in_data) : s1_mag_q;
        e_x      = (zero || XW'(lead) < XW'(MW)) ? '0 : XW'(lead) - XW'(MW - 1);
        low_mask = (DW'(1) << e_x) - DW'(1);
        sat2     = e_x > XW'(EMAX);
        s2_v_d   = advance ? s1_v_q : s2_v_q;
        s2_d     = advance ? '{s:      s1_s_q,
                               e:      sat2 ? '1 : EW'(e_x),
                               f:      sat2 ? '1 : MW'(s1_mag_q >> e_x),
                               guard:  |(s1_mag_q & (low_mask ^ (low_mask >> 1))),
                               sticky: |(s1_mag_q & (low_mask >> 1)),
                               sat:    sat2} : s2_q;
        round_up = !s2_q.sat && s2_q.guard && (!RNE || s2_q.sticky || s2_q.f[0]);
        f_rnd    = {1'b0, s2_q.f} + (MW+1)'(round_up);
        // Mantissa carry-out renormalises; at the top exponent it clamps instead.
        ovf         = f_rnd[MW] && (&s2_q.e);
        out_valid_d = advance ? s2_v_q : out_valid_q;
        out_s_d     = advance ? s2_q.s : out_s_q;
        out_sat_d   = advance ? (s2_q.sat || ovf) : out_sat_q;
        out_e_d     = !advance ? out_e_q : (s2_q.sat || ovf) ? '1 : s2_q.e + EW'(f_rnd[MW]);
        out_f_d     = !advance ? out_f_q : (s2_q.sat || ovf) ? '1 :
                      f_rnd[MW] ? f_rnd[MW:1] : f_rnd[MW-1:0];
        sat_count_d = (out_valid_q && out_ready && out_sat_q && !(&sat_count_q)) ?
                      sat_count_q + CW'(1) : sat_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_s_q      <= 1'b0;
            s1_mag_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            out_s_q     <= 1'b0;
            out_e_q     <= '0;
            out_f_q     <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_s_q      <= s1_s_d;
            s1_mag_q    <= s1_mag_d;
            s2_v_q      <= s2_v_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            out_s_q     <= out_s_d;
            out_e_q     <= out_e_d;
            out_f_q     <= out_f_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_s     = out_s_q;
    assign out_e     = out_e_q;
    assign out_f     = out_f_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// tb_fpcvt_pipe: directed self-checking bench for fpcvt_pipe (DW=12, EW=3, MW=4, CW=8).
module tb_fpcvt_pipe;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, out_s, out_sat;
    logic [11:0] in_data = '0;
    logic [2:0]  out_e;
    logic [3:0]  out_f;
    logic [7:0]  sat_count;
    int          n_chk = 0, n_fail = 0;
    logic [11:0] vec_d [12];
    logic [8:0]  vec_x [12];

`ifdef FPCVT_RNE_EN
    localparam logic [3:0] F21 = 4'b1010, F1088 = 4'b1000;
`else
    localparam logic [3:0] F21 = 4'b1011, F1088 = 4'b1001;
`endif

    always #5 clk = ~clk;

    fpcvt_pipe #(.DW(12), .EW(3), .MW(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_e(out_e),
        .out_f(out_f), .out_sat(out_sat), .sat_count(sat_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] obs();
        return {out_s, out_e, out_f, out_sat};
    endfunction

    task automatic run_one(input int i);
        int lat = 1;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = vec_d[i];
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        chk($sformatf("latency[%0d]", i), lat, 3);
        chk($sformatf("result[%0d]", i), obs(), vec_x[i]);
    endtask

    initial begin
        int tx = 0, rx = 0, cyc = 0, seen = 0;
        logic [8:0] prev = '0;
        logic stall = 1'b0;
        vec_d = '{12'h000, 12'd422, 12'd125, 12'h7FF, 12'h800, 12'd21,
                  12'hE5A, 12'd31, 12'd23, 12'd1088, 12'hFFF, 12'd7};
        vec_x = '{{1'b0, 3'd0, 4'b0000, 1'b0}, {1'b0, 3'd5, 4'b1101, 1'b0},
                  {1'b0, 3'd4, 4'b1000, 1'b0}, {1'b0, 3'd7, 4'b1111, 1'b1},
                  {1'b1, 3'd7, 4'b1111, 1'b1}, {1'b0, 3'd1, F21,     1'b0},
                  {1'b1, 3'd5, 4'b1101, 1'b0}, {1'b0, 3'd2, 4'b1000, 1'b0},
                  {1'b0, 3'd1, 4'b1100, 1'b0}, {1'b0, 3'd7, F1088,   1'b0},
                  {1'b1, 3'd0, 4'b0001, 1'b0}, {1'b0, 3'd0, 4'b0111, 1'b0}};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_payload", obs(), 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_one(i);
        repeat (2) @(posedge clk);
        #1;
        chk("drained", out_valid, 0);
        chk("sat_count_directed", sat_count, 2);

        // 8-sample stream with a 5-cycle downstream stall in the middle
        while (rx < 8 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            in_valid  = tx < 8;
            in_data   = vec_d[tx < 8 ? tx : 0];
            #1;
            if (stall) chk("stall_hold", {out_valid, obs()}, {1'b1, prev});
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                chk($sformatf("stream[%0d]", rx), obs(), vec_x[rx]);
                rx++;
            end
            if (in_valid && in_ready) tx++;
            stall = out_valid && !out_ready;
            prev  = obs();
            @(posedge clk);
            #1 cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", rx, 8);
        repeat (2) @(posedge clk);
        #1;
        chk("sat_count_stream", sat_count, 4);

        // fill the pipe with three samples, then reset mid-stream
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = vec_d[3 + k];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sat_count", sat_count, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        chk("no_stale", seen, 0);
        run_one(1);
        run_one(4);
        repeat (2) @(posedge clk);
        #1;
        chk("sat_count_after_rst", sat_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
